// File: rtl/sdvm_mul_ctrl.sv
// Digit sequencer for the SDVM partial-product stage: captures a signed-digit
// multiplier, issues it MSD first and times the shift-accumulator strobes.
module sdvm_mul_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_DIGITS-1:0] y_plus,
  input  logic [NUM_DIGITS-1:0] y_minus,
  output logic [1:0]            STATE,
  output logic [1:0]            digit_select,
  output logic                  write_enable,
  output logic                  acc_clear,
  output logic                  acc_en,
  output logic [CNT_W-1:0]      digit_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      counter;
  logic [NUM_DIGITS-1:0] shadow_plus;
  logic [NUM_DIGITS-1:0] shadow_minus;

  // acc_en trails RUN by one cycle to line up with the datapath's delayed digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      shadow_plus  <= '0;
      shadow_minus <= '0;
      acc_en       <= 1'b0;
      done         <= 1'b0;
    end else begin
      done   <= 1'b0;
      acc_en <= (state == RUN) && !abort;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            shadow_plus  <= y_plus;
            shadow_minus <= y_minus;
            counter      <= CNT_W'(NUM_DIGITS - 1);
            state        <= LOAD;
          end
        end
        LOAD: begin
          state <= abort ? IDLE : RUN;
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (counter == '0) begin
            state <= DRAIN;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        DRAIN: begin
          state <= IDLE;
          done  <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic cur_plus;
  logic cur_minus;

  assign cur_plus     = shadow_plus[counter];
  assign cur_minus    = shadow_minus[counter];
  assign STATE        = state;
  assign digit_index  = counter;
  assign busy         = (state != IDLE);
  assign write_enable = (state == LOAD) || (state == RUN);
  assign acc_clear    = (state == LOAD);

  // Equal plus/minus bits cancel to a zero digit.
  always_comb begin
    digit_select = 2'b00;
    if (state == RUN) begin
      if (cur_plus && !cur_minus) begin
        digit_select = 2'b10;
      end else if (!cur_plus && cur_minus) begin
        digit_select = 2'b01;
      end
    end
  end

endmodule
